// File: rtl/seq_multiplier_param_if.sv
// seq_multiplier_param_if: Start/Ready/Done handshake and operand/product bus for the shift-add multiplier.
// Signed_op exists only when MULT_SIGNED_EN is defined.
interface seq_multiplier_param_if #(
  parameter int DP_WIDTH = 5
);
  logic                    Start;
  logic [DP_WIDTH-1:0]     Multiplicand;
  logic [DP_WIDTH-1:0]     Multiplier;
  logic [2*DP_WIDTH-1:0]   Product;
  logic                    Ready;
  logic                    Done;
`ifdef MULT_SIGNED_EN
  logic                    Signed_op;
`endif

  modport master (
`ifdef MULT_SIGNED_EN
    output Signed_op,
`endif
    output Start, Multiplicand, Multiplier,
    input  Product, Ready, Done
  );

  modport slave (
`ifdef MULT_SIGNED_EN
    input  Signed_op,
`endif
    input  Start, Multiplicand, Multiplier,
    output Product, Ready, Done
  );
endinterface

// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: DP_WIDTH x DP_WIDTH shift-add multiplier, MULT_SIGNED_EN adds Booth radix-2 signed mode.
// Latency: Done pulses DP_WIDTH+1 edges after the accepted Start; Ready returns one edge after Done.
// Backpressure: Start is ignored while Ready is low; Product holds until the next Done.
module seq_multiplier_param #(
  parameter int DP_WIDTH = 5
) (
  input logic                   clock,
  input logic                   reset,
  seq_multiplier_param_if.slave bus
);
  localparam int PW = $clog2(DP_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                state;
  logic [DP_WIDTH:0]     acc;      // {C,A} unsigned, sign-extended A in Booth mode
  logic [DP_WIDTH-1:0]   q;
  logic [DP_WIDTH-1:0]   b;
  logic [PW-1:0]         p;
  logic [2*DP_WIDTH-1:0] product;
  logic                  ready;
  logic                  done;
`ifdef MULT_SIGNED_EN
  logic                  q_1;
  logic                  signed_r;
`endif

  logic [DP_WIDTH:0]     sum;
  logic [DP_WIDTH:0]     acc_nxt;
  logic [DP_WIDTH-1:0]   q_nxt;

  always_comb begin
    sum     = acc;
    acc_nxt = acc;
`ifdef MULT_SIGNED_EN
    if (signed_r) begin
      case ({q[0], q_1})
        2'b10:   sum = acc - {b[DP_WIDTH-1], b};
        2'b01:   sum = acc + {b[DP_WIDTH-1], b};
        default: sum = acc;
      endcase
      acc_nxt = {sum[DP_WIDTH], sum[DP_WIDTH:1]};
    end else begin
      sum     = q[0] ? (acc + {1'b0, b}) : acc;
      acc_nxt = {1'b0, sum[DP_WIDTH:1]};
    end
`else
    sum     = q[0] ? (acc + {1'b0, b}) : acc;
    acc_nxt = {1'b0, sum[DP_WIDTH:1]};
`endif
    q_nxt = {sum[0], q[DP_WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      acc     <= '0;
      q       <= '0;
      b       <= '0;
      p       <= '0;
      product <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
`ifdef MULT_SIGNED_EN
      q_1      <= 1'b0;
      signed_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Ready comes back one cycle after the Done pulse, so Start is gated on it
          if (!ready) begin
            ready <= 1'b1;
          end else if (bus.Start) begin
            b     <= bus.Multiplicand;
            q     <= bus.Multiplier;
            acc   <= '0;
            p     <= PW'(DP_WIDTH);
            ready <= 1'b0;
            state <= S_CALC;
`ifdef MULT_SIGNED_EN
            q_1      <= 1'b0;
            signed_r <= bus.Signed_op;
`endif
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          p   <= p - PW'(1);
`ifdef MULT_SIGNED_EN
          q_1 <= q[0];
`endif
          if (p == PW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          product <= {acc[DP_WIDTH-1:0], q};
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Product = product;
  assign bus.Ready   = ready;
  assign bus.Done    = done;
endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param: latency, hold, ignore-while-busy, reset abort, back-to-back,
// and (with MULT_SIGNED_EN) signed Booth products.
module tb_seq_multiplier_param;
  localparam int W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seq_multiplier_param_if #(.DP_WIDTH(W)) bus ();
  seq_multiplier_param #(.DP_WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_mul(input logic [W-1:0] mc, input logic [W-1:0] mr,
                         input logic [2*W-1:0] expp, input string tag, input bit mid_start);
    int cnt;
`ifdef MULT_SIGNED_EN
    logic s;
    s = bus.Signed_op;
`endif
    cnt = 0;
    while (!bus.Ready && cnt < 20) begin tick(); cnt++; end
    check({tag, " ready_before"}, 32'(bus.Ready), 1);
    bus.Multiplicand = mc;
    bus.Multiplier   = mr;
    bus.Start        = 1'b1;
    tick();
    bus.Start        = 1'b0;
    bus.Multiplicand = ~mc;
    bus.Multiplier   = ~mr;
`ifdef MULT_SIGNED_EN
    bus.Signed_op    = ~s;
`endif
    check({tag, " busy"}, 32'(bus.Ready), 0);
    cnt = 0;
    while (!bus.Done && cnt < 20) begin
      bus.Start = mid_start && (cnt == 2);
      if (bus.Start) begin bus.Multiplicand = 5'd1; bus.Multiplier = 5'd1; end
      tick();
      cnt++;
    end
    bus.Start = 1'b0;
    check({tag, " latency"}, 32'(cnt), W + 1);
    check({tag, " product"}, 32'(bus.Product), 32'(expp));
    check({tag, " ready_at_done"}, 32'(bus.Ready), 0);
    tick();
    check({tag, " done_width"}, 32'(bus.Done), 0);
    check({tag, " ready_after"}, 32'(bus.Ready), 1);
    check({tag, " product_hold"}, 32'(bus.Product), 32'(expp));
`ifdef MULT_SIGNED_EN
    bus.Signed_op = s;
`endif
  endtask

  initial begin
    int cnt;
    int dones;
    logic [W-1:0]   mcs [3];
    logic [W-1:0]   mrs [3];
    logic [2*W-1:0] exps[3];

    bus.Start        = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
`ifdef MULT_SIGNED_EN
    bus.Signed_op    = 1'b0;
`endif
    reset = 1'b1;
    tick();
    tick();
    check("reset product", 32'(bus.Product), 0);
    check("reset ready",   32'(bus.Ready),   1);
    check("reset done",    32'(bus.Done),    0);
    reset = 1'b0;
    tick();

    run_mul(5'b10111, 5'b10011, 10'd437, "t1 23x19", 1'b0);
    run_mul(5'b11111, 5'b11111, 10'd961, "t2 31x31", 1'b0);
    run_mul(5'b00000, 5'b10101, 10'd0,   "t2 0x21",  1'b0);
    run_mul(5'b01101, 5'b01011, 10'd143, "t3 13x11 mid start", 1'b1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.Done) dones++; end
    check("t3 extra done", 32'(dones), 0);
    check("t3 idle ready", 32'(bus.Ready), 1);
    check("t3 held",       32'(bus.Product), 143);

    // Abort a multiply with reset during its third step.
    bus.Multiplicand = 5'd31;
    bus.Multiplier   = 5'd30;
    bus.Start        = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4 abort product", 32'(bus.Product), 0);
    check("t4 abort ready",   32'(bus.Ready),   1);
    check("t4 abort done",    32'(bus.Done),    0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.Done) dones++; end
    check("t4 no done", 32'(dones), 0);
    run_mul(5'd7, 5'd9, 10'd63, "t4 after abort", 1'b0);

    bus.Multiplicand = 5'd3;
    bus.Multiplier   = 5'd3;
    bus.Start        = 1'b1;
    reset            = 1'b1;
    tick();
    reset     = 1'b0;
    bus.Start = 1'b0;
    check("t4 reset wins ready",   32'(bus.Ready),   1);
    check("t4 reset wins product", 32'(bus.Product), 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.Done) dones++; end
    check("t4 reset wins no done", 32'(dones), 0);

    // Start held high: three back-to-back multiplies.
    mcs[0] = 5'd3;  mrs[0] = 5'd5;  exps[0] = 10'd15;
    mcs[1] = 5'd12; mrs[1] = 5'd13; exps[1] = 10'd156;
    mcs[2] = 5'd31; mrs[2] = 5'd2;  exps[2] = 10'd62;
    bus.Multiplicand = mcs[0];
    bus.Multiplier   = mrs[0];
    bus.Start        = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      while (!bus.Done && cnt < 20) begin tick(); cnt++; end
      check($sformatf("t5 latency %0d", k), 32'(cnt), W + 1);
      check($sformatf("t5 product %0d", k), 32'(bus.Product), 32'(exps[k]));
      if (k < 2) begin
        bus.Multiplicand = mcs[k+1];
        bus.Multiplier   = mrs[k+1];
      end else begin
        bus.Start = 1'b0;
      end
      tick();
      check($sformatf("t5 done width %0d", k), 32'(bus.Done), 0);
      check($sformatf("t5 ready %0d", k),      32'(bus.Ready), 1);
      tick();
      check($sformatf("t5 accepted %0d", k),   32'(bus.Ready), (k < 2) ? 0 : 1);
      check($sformatf("t5 hold %0d", k),       32'(bus.Product), 32'(exps[k]));
    end
    bus.Start = 1'b0;

`ifdef MULT_SIGNED_EN
    bus.Signed_op = 1'b1;
    run_mul(5'b10111, 5'b10011, 10'b0001110101, "t6 s -9x-13",   1'b0);
    run_mul(5'b10000, 5'b10000, 10'b0100000000, "t6 s -16x-16",  1'b0);
    run_mul(5'b01111, 5'b10000, 10'b1100010000, "t6 s 15x-16",   1'b0);
    bus.Signed_op = 1'b0;
`endif
    run_mul(5'b10111, 5'b10011, 10'd437, "t6 u 23x19", 1'b0);
    run_mul(5'b10000, 5'b10000, 10'd256, "t6 u 16x16", 1'b0);
    run_mul(5'b01111, 5'b10000, 10'd240, "t6 u 15x16", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
